deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Parameters
REQ-001 WIDTH, 8, number of serial bits per word and width of the parallel output.
REQ-002 GAP_MAX, 0, maximum consecutive in_en-low cycles tolerated inside a partially received word.

Interface
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in  input  1  serial data bit; sampled only when in_en=1.
REQ-006 in_en  input  1  serial bit valid; one bit per clk cycle while high.
REQ-007 out  output  WIDTH  last completed parallel word; registered.
REQ-008 out_valid  output  1  one-cycle pulse marking a new value on out.
REQ-009 frame_err  output  1  one-cycle pulse marking an aborted partial word.
REQ-010 busy  output  1  high while a partial word (1..WIDTH-1 bits) is held.

Function
REQ-011 Bit order SHALL be LSB first: first accepted bit of a word lands in out[0], WIDTH-th bit in out[WIDTH-1].
REQ-012 Block SHALL use two states: IDLE (bit count 0) and SHIFT (bit count 1..WIDTH-1).
REQ-013 IDLE: in_en=1 SHALL capture in as bit 0, set bit count to 1, go to SHIFT; in_en=0 SHALL hold IDLE.
REQ-014 SHIFT, in_en=1: SHALL shift in the bit, increment bit count, and clear the gap counter.
REQ-015 When the WIDTH-th bit is sampled, the assembled word SHALL be loaded into out and out_valid SHALL be high in the immediately following cycle (latency 1 clk after last-bit edge); state returns to IDLE with bit count 0.
REQ-016 Back-to-back words SHALL be supported: in_en held high for k*WIDTH cycles SHALL produce k out_valid pulses, WIDTH cycles apart, with no lost bits.
REQ-017 SHIFT, in_en=0: gap counter SHALL increment; partial word and bit count SHALL be held while gap count <= GAP_MAX.
REQ-018 When a gap reaches GAP_MAX+1 cycles, the partial word SHALL be discarded, frame_err SHALL pulse for exactly one cycle, state SHALL return to IDLE; out SHALL NOT change.
REQ-019 With GAP_MAX=0, any in_en-low cycle in SHIFT SHALL trigger REQ-018 on that cycle's edge.
REQ-020 out SHALL hold its value between out_valid pulses; out_valid and frame_err SHALL never be high in the same cycle.
REQ-021 busy SHALL equal (state == SHIFT), including during tolerated gaps.
REQ-022 in SHALL be ignored whenever in_en=0.
REQ-023 Bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and gap counter ceil(log2(GAP_MAX+2)) bits; neither SHALL wrap.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, bit count 0, gap count 0, out=0, out_valid=0, frame_err=0, busy=0, independent of clk.
REQ-025 Reset asserted mid-word SHALL discard the partial word without a frame_err pulse.
REQ-026 After rst deasserts, the first clk edge with in_en=1 SHALL be taken as bit 0 of a new word.

Verification
REQ-027 WIDTH=8: in_en=1 for 8 cycles, in=1,0,1,0,0,1,0,1 -> one cycle later out=0xA5, out_valid pulses once, busy high for cycles 2..8 only.
REQ-028 in_en=1 for 16 cycles carrying 0x3C then 0xC3 LSB first -> out_valid pulses twice, 8 cycles apart, out=0x3C then 0xC3.
REQ-029 GAP_MAX=0: 3 bits, then in_en=0 one cycle -> frame_err one-cycle pulse, out keeps previous value, no out_valid; following full 0x5A received correctly.
REQ-030 GAP_MAX=2: 4 bits of 0x96, 2-cycle gap, remaining 4 bits -> out=0x96, no frame_err; repeat with 3-cycle gap -> frame_err, no out_valid.
REQ-031 rst pulsed asynchronously (between clk edges) after 5 bits -> outputs cleared immediately, no frame_err; next 8 bits 0xFF -> out=0xFF.
REQ-032 in toggling randomly with in_en=0 for 20 cycles in IDLE -> no out_valid, no frame_err, busy=0, out unchanged.

Source files
------------

// File: rtl/deserializer.sv
// deserializer: LSB-first serial-to-parallel converter with gap tolerance and frame abort
module deserializer #(
  parameter int WIDTH = 8,
  parameter int GAP_MAX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             frame_err,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP_MAX + 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gap, gap_n;
  logic [WIDTH-1:0] sh, sh_n, word, out_n;
  logic last, abort;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      gap <= '0;
      sh <= '0;
      out <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gap <= gap_n;
      sh <= sh_n;
      out <= out_n;
      out_valid <= last;
      frame_err <= abort;
    end
  // sh is zero above the current bit count, so OR-ing places the new bit at position cnt
  always_comb begin
    word = sh | (WIDTH'(in) << cnt);
    last = in_en && cnt == CW'(WIDTH - 1);
    abort = state == SHIFT && !in_en && gap == GW'(GAP_MAX);
    state_n = (last || abort) ? IDLE : in_en ? SHIFT : state;
    cnt_n = (last || abort) ? '0 : in_en ? cnt + 1'b1 : cnt;
    gap_n = (in_en || abort || state == IDLE) ? '0 : gap + 1'b1;
    sh_n = (last || abort) ? '0 : in_en ? word : sh;
    out_n = last ? word : out;
  end
  assign busy = state == SHIFT;
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed checks of the deserializer with GAP_MAX=0 and GAP_MAX=2 instances
module tb_deserializer;
  logic clk = 1'b0, rst = 1'b1;
  logic in0 = 1'b0, en0 = 1'b0, in2 = 1'b0, en2 = 1'b0;
  logic [7:0] out0, out2;
  logic v0, v2, e0, e2, b0, b2;
  int errs = 0, checks = 0;

  deserializer #(.WIDTH(8), .GAP_MAX(0)) d0 (.clk(clk), .rst(rst), .in(in0), .in_en(en0),
    .out(out0), .out_valid(v0), .frame_err(e0), .busy(b0));
  deserializer #(.WIDTH(8), .GAP_MAX(2)) d2 (.clk(clk), .rst(rst), .in(in2), .in_en(en2),
    .out(out2), .out_valid(v2), .frame_err(e2), .busy(b2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit sel, input logic e, input logic b);
    @(negedge clk);
    en0 = sel ? 1'b0 : e;
    in0 = sel ? 1'b0 : b;
    en2 = sel ? e : 1'b0;
    in2 = sel ? b : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input bit sel, input logic [7:0] w, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      step(sel, 1'b1, w[i]);
      chk("err_in_word", sel ? e2 : e0, 0);
      if (i < 7) begin
        chk("busy_mid", sel ? b2 : b0, 1);
        chk("valid_mid", sel ? v2 : v0, 0);
      end else begin
        chk("valid_end", sel ? v2 : v0, 1);
        chk("out_end", sel ? out2 : out0, w);
        chk("busy_end", sel ? b2 : b0, 0);
      end
    end
  endtask

  initial begin
    #2;
    chk("rst_out", out0, 0);
    chk("rst_valid", v0, 0);
    chk("rst_err", e0, 0);
    chk("rst_busy", b0, 0);
    @(negedge clk) rst = 1'b0;
    // single word 0xA5, then a quiet cycle
    send_bits(0, 8'hA5, 0, 7);
    step(0, 1'b0, 1'b1);
    chk("a5_valid_pulse", v0, 0);
    chk("a5_hold", out0, 8'hA5);
    chk("a5_busy_idle", b0, 0);
    // back-to-back words
    send_bits(0, 8'h3C, 0, 7);
    send_bits(0, 8'hC3, 0, 7);
    // GAP_MAX=0 abort after 3 bits
    send_bits(0, 8'hFF, 0, 2);
    step(0, 1'b0, 1'b1);
    chk("g0_err", e0, 1);
    chk("g0_busy", b0, 0);
    chk("g0_valid", v0, 0);
    chk("g0_out", out0, 8'hC3);
    step(0, 1'b0, 1'b0);
    chk("g0_err_pulse", e0, 0);
    send_bits(0, 8'h5A, 0, 7);
    // GAP_MAX=2: tolerated 2-cycle gap
    send_bits(1, 8'h96, 0, 3);
    repeat (2) begin
      step(1, 1'b0, 1'b1);
      chk("g2_gap_busy", b2, 1);
      chk("g2_gap_err", e2, 0);
    end
    send_bits(1, 8'h96, 4, 7);
    // 3-cycle gap aborts
    send_bits(1, 8'h0F, 0, 3);
    step(1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b0);
    chk("g3_busy_before", b2, 1);
    chk("g3_err_before", e2, 0);
    step(1, 1'b0, 1'b0);
    chk("g3_err", e2, 1);
    chk("g3_valid", v2, 0);
    chk("g3_busy", b2, 0);
    chk("g3_out", out2, 8'h96);
    step(1, 1'b0, 1'b0);
    chk("g3_err_pulse", e2, 0);
    // async reset mid-word
    send_bits(0, 8'hFF, 0, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_out", out0, 0);
    chk("arst_busy", b0, 0);
    chk("arst_valid", v0, 0);
    chk("arst_err", e0, 0);
    rst = 1'b0;
    send_bits(0, 8'hFF, 0, 7);
    // random in with in_en low
    for (int i = 0; i < 20; i++) begin
      step(0, 1'b0, 1'($urandom_range(0, 1)));
      chk("idle_valid", v0, 0);
      chk("idle_err", e0, 0);
      chk("idle_busy", b0, 0);
      chk("idle_out", out0, 8'hFF);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
